// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_pkg : shared types and constants for the multi-cycle MIPS controller
// Revision : 1.0
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam int ALUC_W = 3;
  localparam int OP_W   = 6;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALU_AND = 3'd0;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'd1;
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'd2;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'd6;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'd7;

endpackage
`default_nettype wire

// File: rtl/mips_mc_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_mc_controller_if : controller <-> datapath signal bundle
// Revision : 1.0
// ----------------------------------------------------------------------------
interface mips_mc_controller_if;
  import mips_pkg::*;

  logic [OP_W-1:0]   op;
  logic [OP_W-1:0]   funct;
  logic              zero;
  logic              pcen;
  logic              iord;
  logic              memwrite;
  logic              irwrite;
  logic              regdst;
  logic              memtoreg;
  logic              regwrite;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic [1:0]        pcsrc;
  logic [ALUC_W-1:0] ALUcontrol;
  logic              illegal_op;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, ALUcontrol, illegal_op
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, ALUcontrol, illegal_op
  );

endinterface
`default_nettype wire

// File: rtl/mips_mc_controller_alu_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_decoder : maps (ALUOp, funct) to the 3-bit ALUcontrol code
// Revision : 1.0
// ----------------------------------------------------------------------------
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t            aluop,
  input  logic [OP_W-1:0]   funct,
  output logic [ALUC_W-1:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct falls back to add; no trap is raised.
        case (funct)
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_mc_controller : Moore FSM sequencing fetch/decode/execute/mem/writeback
// Revision : 1.0
// ----------------------------------------------------------------------------
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  mips_mc_controller_if.master bus
);

  state_t r_state;
  state_t w_next;
  aluop_t w_aluop;
  aluop_t w_aluop_g;
  logic   w_pcwrite, w_branch, w_iord, w_memwrite, w_irwrite, w_regdst;
  logic   w_memtoreg, w_regwrite, w_alusrca, w_illegal;
  logic [1:0] w_alusrcb, w_pcsrc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_aluop    = ALUOP_ADD;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset masks the decode so no write or select escapes while reset_n is low.
  assign w_aluop_g      = reset_n ? w_aluop : ALUOP_ADD;
  assign bus.pcen       = reset_n & (w_pcwrite | (w_branch & bus.zero));
  assign bus.iord       = reset_n & w_iord;
  assign bus.memwrite   = reset_n & w_memwrite;
  assign bus.irwrite    = reset_n & w_irwrite;
  assign bus.regdst     = reset_n & w_regdst;
  assign bus.memtoreg   = reset_n & w_memtoreg;
  assign bus.regwrite   = reset_n & w_regwrite;
  assign bus.alusrca    = reset_n & w_alusrca;
  assign bus.alusrcb    = reset_n ? w_alusrcb : 2'b00;
  assign bus.pcsrc      = reset_n ? w_pcsrc : 2'b00;
  assign bus.illegal_op = reset_n & w_illegal;

  alu_decoder u_alu_decoder (
    .aluop      (w_aluop_g),
    .funct      (bus.funct),
    .alucontrol (bus.ALUcontrol)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mips_mc_controller : scoreboard bench with a per-instruction step model
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_mips_mc_controller;

  typedef struct packed {
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluc;
    logic       illegal;
  } outs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   release_pending = 1'b0;
  outs_t expq[$];
  string nameq[$];

  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] funct_code(input logic [5:0] f);
    case (f)
      6'b100000: return 3'd2;
      6'b100010: return 3'd6;
      6'b100100: return 3'd0;
      6'b100101: return 3'd1;
      6'b101010: return 3'd7;
      default:   return 3'd2;
    endcase
  endfunction

  function automatic outs_t reset_outs();
    outs_t e = '0;
    e.aluc = 3'd2;
    return e;
  endfunction

  function automatic outs_t exp_step(input string s, input logic [5:0] f, input logic z);
    outs_t e = '0;
    e.aluc = 3'd2;
    case (s)
      "F":   begin e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; end
      "D":   e.alusrcb = 2'b11;
      "DI":  begin e.alusrcb = 2'b11; e.illegal = 1; end
      "MA":  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      "MRD": e.iord = 1;
      "MWB": begin e.memtoreg = 1; e.regwrite = 1; end
      "MWR": begin e.iord = 1; e.memwrite = 1; end
      "EX":  begin e.alusrca = 1; e.aluc = funct_code(f); end
      "AWB": begin e.regdst = 1; e.regwrite = 1; end
      "BR":  begin e.alusrca = 1; e.pcsrc = 2'b01; e.aluc = 3'd6; e.pcen = z; end
      "AX":  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      "AXW": e.regwrite = 1;
      "J":   begin e.pcsrc = 2'b10; e.pcen = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      expq.push_back(reset_outs());
      nameq.push_back("reset");
    end
    release_pending = 1'b1;
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input bit mid_reset);
    string steps[$];
    case (o)
      6'b000000: steps = '{"F", "D", "EX", "AWB"};
      6'b100011: steps = '{"F", "D", "MA", "MRD", "MWB"};
      6'b101011: steps = '{"F", "D", "MA", "MWR"};
      6'b000100: steps = '{"F", "D", "BR"};
      6'b001000: steps = '{"F", "D", "AX", "AXW"};
      6'b000010: steps = '{"F", "D", "J"};
      default:   steps = '{"F", "DI"};
    endcase
    foreach (steps[k]) begin
      @(posedge clk); #1;
      if (release_pending) begin
        reset_n = 1'b1;
        release_pending = 1'b0;
      end
      bus.op    = o;
      bus.funct = f;
      bus.zero  = 1'($urandom_range(0, 1));
      expq.push_back(exp_step(steps[k], f, bus.zero));
      nameq.push_back(steps[k]);
      if (mid_reset && steps[k] == "MWR") begin
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.memwrite !== 1'b0) begin
          bad++;
          $display("FAIL async_memwrite_drop got=%b want=0", bus.memwrite);
        end
        reset_cycles(2);
      end
    end
  endtask

  function automatic logic [5:0] rand_funct();
    logic [5:0] fl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    if ($urandom_range(0, 9) < 7) return fl[$urandom_range(0, 4)];
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] ol[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    int sel = $urandom_range(0, 6);
    logic [5:0] o;
    if (sel < 6) return ol[sel];
    do o = 6'($urandom_range(0, 63));
    while (o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
    return o;
  endfunction

  always @(negedge clk) begin
    outs_t act, e;
    string n;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      n = nameq.pop_front();
      act = '{bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
              bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.ALUcontrol, bus.illegal_op};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL step_%s t=%0t got=%h want=%h op=%b funct=%b zero=%b",
                 n, $time, act, e, bus.op, bus.funct, bus.zero);
      end
    end
  end

  initial begin
    bus.op = 6'b0;
    bus.funct = 6'b0;
    bus.zero = 1'b0;
    reset_cycles(3);
    do_instr(6'b100011, 6'b000000, 1'b0);
    do_instr(6'b000000, 6'b100010, 1'b0);
    do_instr(6'b000000, 6'b101010, 1'b0);
    do_instr(6'b000000, 6'b100100, 1'b0);
    do_instr(6'b000000, 6'b100101, 1'b0);
    do_instr(6'b000000, 6'b111000, 1'b0);
    for (int i = 0; i < 6; i++) do_instr(6'b000100, 6'b000000, 1'b0);
    do_instr(6'b111111, 6'b000000, 1'b0);
    do_instr(6'b101011, 6'b000000, 1'b1);
    do_instr(6'b001000, 6'b000000, 1'b0);
    do_instr(6'b000010, 6'b000000, 1'b0);
    for (int i = 0; i < 300; i++) do_instr(rand_op(), rand_funct(), ($urandom_range(0, 19) == 0));
    repeat (2) @(posedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
